hazard_control_unit: RTL and testbench

Next-generation hazard unit for the 5-stage RISC-V pipeline (FE/DE/EX/ME/WB). It adds four things to the basic load-use stall:
- parametrised register-address width;
- x0 and operand-use qualification;
- taken-branch flush;
- a wait-state FSM that freezes the whole pipeline while the data memory completes a multi-cycle access.

It also keeps saturating stall/flush event counters for performance debug. It drives all pipeline-register enables and clears.

---
 rtl/hazard_control_unit_if.sv | 38 +++
 rtl/hazard_control_unit.sv | 134 +++++++++++++
 tb/tb_hazard_control_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_if.sv
// Pipeline hazard bus: DE/EX/ME hazard inputs toward the hazard unit and the
// pipeline-register enables, clears and debug counters coming back.
interface hazard_control_unit_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic [REG_W-1:0] rs1_de;
  logic [REG_W-1:0] rs2_de;
  logic             use_rs1_de;
  logic             use_rs2_de;
  logic [REG_W-1:0] rd_ex;
  logic             DMRd_ex;
  logic             br_taken_ex;
  logic             mem_acc_me;
  logic             en_pc_fe;
  logic             en_pc_inc_de;
  logic             en_de_ex;
  logic             en_ex_me;
  logic             en_me_wb;
  logic             clr_de;
  logic             clr_ex;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1_de, rs2_de, use_rs1_de, use_rs2_de, rd_ex, DMRd_ex,
           br_taken_ex, mem_acc_me,
    input  en_pc_fe, en_pc_inc_de, en_de_ex, en_ex_me, en_me_wb,
           clr_de, clr_ex, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_de, rs2_de, use_rs1_de, use_rs2_de, rd_ex, DMRd_ex,
           br_taken_ex, mem_acc_me,
    output en_pc_fe, en_pc_inc_de, en_de_ex, en_ex_me, en_me_wb,
           clr_de, clr_ex, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard control for the 5-stage pipeline: load-use bubble, taken-branch flush,
// multi-cycle data-memory freeze, plus saturating stall/flush event counters.
module hazard_control_unit #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 16
) (
  input logic                 clk,
  input logic                 rst,
  hazard_control_unit_if.slave hz
);

  localparam int unsigned WAIT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  typedef enum logic {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              mem_stall;

  logic [REG_W-1:0]  rs1;
  logic [REG_W-1:0]  rs2;
  logic [REG_W-1:0]  rd;
  logic              load_use;

  logic              en_pc_fe;
  logic              en_pc_inc_de;
  logic              en_de_ex;
  logic              en_ex_me;
  logic              en_me_wb;
  logic              clr_de;
  logic              clr_ex;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  assign rs1 = hz.rs1_de;
  assign rs2 = hz.rs2_de;
  assign rd  = hz.rd_ex;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency
  assign load_use = !hz.DMRd_ex && (rd != '0) &&
                    ((hz.use_rs1_de && (rs1 == rd)) ||
                     (hz.use_rs2_de && (rs2 == rd)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next state; the release cycle ignores mem_acc_me so the next access starts in RUN
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_stall = 1'b0;
    case (state_q)
      S_RUN: begin
        if ((MEM_WAIT != 0) && hz.mem_acc_me) begin
          mem_stall = 1'b1;
          state_d   = S_MEM_WAIT;
          wait_d    = WAIT_W'(MEM_WAIT - 1);
        end
      end
      S_MEM_WAIT: begin
        if (wait_q != '0) begin
          mem_stall = 1'b1;
          wait_d    = wait_q - 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Outputs by priority: reset, memory freeze, branch flush, load-use bubble
  always_comb begin
    en_pc_fe     = 1'b1;
    en_pc_inc_de = 1'b1;
    en_de_ex     = 1'b1;
    en_ex_me     = 1'b1;
    en_me_wb     = 1'b1;
    clr_de       = 1'b0;
    clr_ex       = 1'b0;
    if (rst) begin
      clr_de = 1'b0;
    end else if (mem_stall) begin
      en_pc_fe     = 1'b0;
      en_pc_inc_de = 1'b0;
      en_de_ex     = 1'b0;
      en_ex_me     = 1'b0;
      en_me_wb     = 1'b0;
    end else if (hz.br_taken_ex) begin
      clr_de = 1'b1;
      clr_ex = 1'b1;
    end else if (load_use) begin
      en_pc_fe     = 1'b0;
      en_pc_inc_de = 1'b0;
      clr_ex       = 1'b1;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!en_pc_fe && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (clr_de && (flush_cnt_q != '1))    flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.en_pc_fe     = en_pc_fe;
  assign hz.en_pc_inc_de = en_pc_inc_de;
  assign hz.en_de_ex     = en_de_ex;
  assign hz.en_ex_me     = en_ex_me;
  assign hz.en_me_wb     = en_me_wb;
  assign hz.clr_de       = clr_de;
  assign hz.clr_ex       = clr_ex;
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: two hazard units (MEM_WAIT=3/CNT_W=4 and MEM_WAIT=0/CNT_W=16)
// driven with identical stimulus and checked against a cycle-level reference model.
module tb_hazard_control_unit;

  localparam int MW_A  = 3;
  localparam int MW_B  = 0;
  localparam int SAT_A = 15;
  localparam int SAT_B = 65535;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       dmrd;
    logic       br;
    logic       mem;
    logic       rst;
  } stim_t;

  typedef struct {
    logic [6:0] oa;
    logic [6:0] ob;
    int         sa;
    int         fa;
    int         sb;
    int         fb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_control_unit_if #(.REG_W(5), .CNT_W(4))  ifa ();
  hazard_control_unit_if #(.REG_W(5), .CNT_W(16)) ifb ();

  hazard_control_unit #(.REG_W(5), .MEM_WAIT(MW_A), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .hz  (ifa)
  );

  hazard_control_unit #(.REG_W(5), .MEM_WAIT(MW_B), .CNT_W(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .hz  (ifb)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: age of the access occupying ME (-1 = none) and event totals
  int age_a = -1, age_b = -1;
  int cnt_sa = 0, cnt_fa = 0, cnt_sb = 0, cnt_fb = 0;

  // Outputs packed as {en_pc_fe, en_pc_inc_de, en_de_ex, en_ex_me, en_me_wb, clr_de, clr_ex}
  function automatic logic [6:0] ref_out(input stim_t s, input bit frozen);
    bit lu;
    lu = !s.dmrd && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    if (s.rst)  return 7'b1111100;
    if (frozen) return 7'b0000000;
    if (s.br)   return 7'b1111111;
    if (lu)     return 7'b0011101;
    return 7'b1111100;
  endfunction

  // An access spends mw+1 cycles in ME; the first mw of them freeze the pipe
  function automatic void ref_mem(input stim_t s, input int mw, input int age,
                                  output bit frozen, output int next_age);
    int cur;
    cur = (age >= 0) ? age : ((mw > 0 && s.mem) ? 0 : -1);
    frozen = (cur >= 0) && (cur < mw);
    if (s.rst || cur < 0 || cur == mw) next_age = -1;
    else next_age = cur + 1;
  endfunction

  function automatic int sat_inc(input int v, input bit hit, input int sat);
    if (hit && v < sat) return v + 1;
    return v;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit   fr_a, fr_b;
    int   na, nb;
    @(posedge clk);
    #1;
    rst             = s.rst;
    ifa.rs1_de      = s.rs1;  ifb.rs1_de      = s.rs1;
    ifa.rs2_de      = s.rs2;  ifb.rs2_de      = s.rs2;
    ifa.rd_ex       = s.rd;   ifb.rd_ex       = s.rd;
    ifa.use_rs1_de  = s.u1;   ifb.use_rs1_de  = s.u1;
    ifa.use_rs2_de  = s.u2;   ifb.use_rs2_de  = s.u2;
    ifa.DMRd_ex     = s.dmrd; ifb.DMRd_ex     = s.dmrd;
    ifa.br_taken_ex = s.br;   ifb.br_taken_ex = s.br;
    ifa.mem_acc_me  = s.mem;  ifb.mem_acc_me  = s.mem;
    ref_mem(s, MW_A, age_a, fr_a, na);
    ref_mem(s, MW_B, age_b, fr_b, nb);
    e.oa = ref_out(s, fr_a);
    e.ob = ref_out(s, fr_b);
    e.sa = cnt_sa; e.fa = cnt_fa; e.sb = cnt_sb; e.fb = cnt_fb;
    exp_q.push_back(e);
    age_a = na;
    age_b = nb;
    if (s.rst) begin
      cnt_sa = 0; cnt_fa = 0; cnt_sb = 0; cnt_fb = 0;
    end else begin
      cnt_sa = sat_inc(cnt_sa, !e.oa[6], SAT_A);
      cnt_fa = sat_inc(cnt_fa, e.oa[1],  SAT_A);
      cnt_sb = sat_inc(cnt_sb, !e.ob[6], SAT_B);
      cnt_fb = sat_inc(cnt_fb, e.ob[1],  SAT_B);
    end
  endtask

  function automatic stim_t mk(input int rs1, input int rs2, input int rd, input bit u1,
                               input bit u2, input bit dmrd, input bit br, input bit mem,
                               input bit r);
    stim_t s;
    s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
    s.u1 = u1; s.u2 = u2; s.dmrd = dmrd; s.br = br; s.mem = mem; s.rst = r;
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents one response
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outs_a", int'({ifa.en_pc_fe, ifa.en_pc_inc_de, ifa.en_de_ex, ifa.en_ex_me,
                            ifa.en_me_wb, ifa.clr_de, ifa.clr_ex}), int'(e.oa));
      check("outs_b", int'({ifb.en_pc_fe, ifb.en_pc_inc_de, ifb.en_de_ex, ifb.en_ex_me,
                            ifb.en_me_wb, ifb.clr_de, ifb.clr_ex}), int'(e.ob));
      check("stall_cnt_a", int'(ifa.stall_cnt), e.sa);
      check("flush_cnt_a", int'(ifa.flush_cnt), e.fa);
      check("stall_cnt_b", int'(ifb.stall_cnt), e.sb);
      check("flush_cnt_b", int'(ifb.flush_cnt), e.fb);
    end
  end

  initial begin
    stim_t idle, s;
    idle = mk(0, 0, 0, 0, 0, 1, 0, 0, 0);
    rst = 1'b1;
    ifa.rs1_de = '0; ifa.rs2_de = '0; ifa.rd_ex = '0; ifa.use_rs1_de = 1'b0;
    ifa.use_rs2_de = 1'b0; ifa.DMRd_ex = 1'b1; ifa.br_taken_ex = 1'b0; ifa.mem_acc_me = 1'b0;
    ifb.rs1_de = '0; ifb.rs2_de = '0; ifb.rd_ex = '0; ifb.use_rs1_de = 1'b0;
    ifb.use_rs2_de = 1'b0; ifb.DMRd_ex = 1'b1; ifb.br_taken_ex = 1'b0; ifb.mem_acc_me = 1'b0;

    // Reset held with hazards present: enables must stay on
    step(mk(5, 0, 5, 1, 0, 0, 1, 1, 1));
    step(idle);
    // Single load-use bubble
    step(mk(5, 0, 5, 1, 0, 0, 0, 0, 0));
    step(idle);
    // x0 destination, then an unused rs2 match
    step(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    step(mk(1, 7, 7, 1, 0, 0, 0, 0, 0));
    step(mk(3, 3, 3, 0, 0, 0, 0, 0, 0));
    // Branch overrides load-use
    step(mk(5, 0, 5, 1, 0, 0, 1, 0, 0));
    step(idle);
    // Memory access held with a taken branch pending across the freeze
    for (int i = 0; i < 5; i++) step(mk(2, 2, 2, 1, 1, 0, 1, 1, 0));
    for (int i = 0; i < 2; i++) step(mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
    step(idle);
    // Reset during the wait, then resume
    step(mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
    step(mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
    step(mk(0, 0, 0, 0, 0, 1, 0, 1, 1));
    step(idle);
    step(mk(0, 0, 0, 0, 0, 1, 0, 1, 0));
    step(idle);
    step(idle);
    step(idle);
    // Counter saturation on the 4-bit instance
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 1));
    for (int i = 0; i < 20; i++) step(mk(0, 9, 9, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) step(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
    step(idle);
    // Randomized traffic with small register indices to make matches common
    for (int i = 0; i < 600; i++) begin
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.rd   = 5'($urandom_range(0, 3));
      s.u1   = 1'($urandom_range(0, 1));
      s.u2   = 1'($urandom_range(0, 1));
      s.dmrd = 1'($urandom_range(0, 1));
      s.br   = ($urandom_range(0, 5) == 0);
      s.mem  = ($urandom_range(0, 4) == 0);
      s.rst  = ($urandom_range(0, 59) == 0);
      step(s);
    end
    step(idle);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
